// File: rtl/core_pkg.sv
// Shared integer-core types: tag/data widths, CDB and issue bundles, RS entry layout.
package core_pkg;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;
   localparam int INST_W = 10;

   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [TAG_W-1:0]  dest;
      logic [DATA_W-1:0] opr1;
      logic [DATA_W-1:0] opr2;
   } rs2exe_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
   } cdb_t;

   // When rdy=0 the low TAG_W bits of val hold the producer tag.
   typedef struct packed {
      logic              rdy;
      logic [DATA_W-1:0] val;
   } rs_operand_t;

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic [TAG_W-1:0]  dest;
      rs_operand_t       opr1;
      rs_operand_t       opr2;
   } rs_entry_t;

   function automatic logic tag_match(input rs_operand_t opd, input cdb_t bc);
      return !opd.rdy && (bc.tag != TAG_NONE) && (opd.val[TAG_W-1:0] == bc.tag);
   endfunction

endpackage

// File: rtl/rs_integer_if.sv
// Dispatch / CDB / issue bundle between the integer RS and its neighbours.
interface rs_integer_if #(parameter int DEPTH = 4) ();

   logic                         flush;
   logic                         disp_valid;
   logic                         disp_ready;
   logic [core_pkg::INST_W-1:0]  disp_inst;
   logic [core_pkg::TAG_W-1:0]   disp_dest;
   logic                         disp_opr1_rdy;
   logic [core_pkg::DATA_W-1:0]  disp_opr1;
   logic                         disp_opr2_rdy;
   logic [core_pkg::DATA_W-1:0]  disp_opr2;
   core_pkg::cdb_t               cdb;
   logic                         exe_en;
   core_pkg::rs2exe_t            rs2exe;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output flush, disp_valid, disp_inst, disp_dest,
             disp_opr1_rdy, disp_opr1, disp_opr2_rdy, disp_opr2, cdb,
      input  disp_ready, exe_en, rs2exe, count
   );

   modport slave (
      input  flush, disp_valid, disp_inst, disp_dest,
             disp_opr1_rdy, disp_opr1, disp_opr2_rdy, disp_opr2, cdb,
      output disp_ready, exe_en, rs2exe, count
   );

endinterface

// File: rtl/rs_operand_wakeup.sv
// Per-operand CDB snoop: a pending operand whose tag matches a live broadcast becomes ready with its value.
module rs_operand_wakeup
   import core_pkg::*;
(
   input  rs_operand_t opd,
   input  cdb_t        cdb,
   output rs_operand_t nxt
);

   always_comb begin
      nxt = opd;
      if (tag_match(opd, cdb)) begin
         nxt.rdy = 1'b1;
         nxt.val = cdb.value;
      end
   end

endmodule

// File: rtl/rs_integer.sv
// Integer reservation station: compacting age queue, CDB wakeup, oldest-ready registered issue.
// Build option CDB_WAKEUP_FORWARD_EN lets a same-cycle CDB match count as ready at select.
module rs_integer
   import core_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   rs_integer_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   rs_entry_t         ent_q  [DEPTH];
   rs_entry_t         ent_wk [DEPTH];
   rs_entry_t         ent_up [DEPTH];
   rs_entry_t         ent_d  [DEPTH];
   rs_operand_t       w1     [DEPTH];
   rs_operand_t       w2     [DEPTH];

   logic [DEPTH-1:0]  rdy_vec;
   logic              sel_vld;
   logic [IDX_W-1:0]  sel_idx;
   rs_entry_t         iss;
   rs2exe_t           sel_bundle;

   rs_operand_t       disp_o1_raw, disp_o2_raw;
   rs_operand_t       disp_o1, disp_o2;
   rs_entry_t         disp_ent;
   logic              disp_fire;
   int                tail;

   logic [CNT_W-1:0]  count_q, count_d;
   logic              exe_en_q;
   rs2exe_t           rs2exe_q;

   // Per-entry wakeup and the down-shifted view used for compaction.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      rs_operand_wakeup u_w1 (.opd(ent_q[g].opr1), .cdb(bus.cdb), .nxt(w1[g]));
      rs_operand_wakeup u_w2 (.opd(ent_q[g].opr2), .cdb(bus.cdb), .nxt(w2[g]));

      if (g < DEPTH - 1) begin : g_up
         assign ent_up[g] = ent_wk[g+1];
      end else begin : g_top
         assign ent_up[g] = '0;
      end

`ifdef CDB_WAKEUP_FORWARD_EN
      assign rdy_vec[g] = ent_wk[g].valid && ent_wk[g].opr1.rdy && ent_wk[g].opr2.rdy;
`else
      assign rdy_vec[g] = ent_q[g].valid && ent_q[g].opr1.rdy && ent_q[g].opr2.rdy;
`endif
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_wk[i]      = ent_q[i];
         ent_wk[i].opr1 = w1[i];
         ent_wk[i].opr2 = w2[i];
      end
   end

   // A dispatch landing in the same cycle as its producer's broadcast must not miss it.
   assign disp_o1_raw = '{rdy: bus.disp_opr1_rdy, val: bus.disp_opr1};
   assign disp_o2_raw = '{rdy: bus.disp_opr2_rdy, val: bus.disp_opr2};

   rs_operand_wakeup u_disp1 (.opd(disp_o1_raw), .cdb(bus.cdb), .nxt(disp_o1));
   rs_operand_wakeup u_disp2 (.opd(disp_o2_raw), .cdb(bus.cdb), .nxt(disp_o2));

   assign disp_ent = '{valid: 1'b1, inst: bus.disp_inst, dest: bus.disp_dest,
                       opr1: disp_o1, opr2: disp_o2};

   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy_vec[i]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
`ifdef CDB_WAKEUP_FORWARD_EN
      iss = ent_wk[sel_idx];
`else
      iss = ent_q[sel_idx];
`endif
      sel_bundle = '{inst: iss.inst, dest: iss.dest, opr1: iss.opr1.val, opr2: iss.opr2.val};
   end

   assign bus.disp_ready = (count_q < CNT_W'(DEPTH));
   assign disp_fire      = bus.disp_valid && bus.disp_ready;

   // Entries at and above the issued slot slide down; a new dispatch lands at the new tail.
   always_comb begin
      tail = int'(count_q) - (sel_vld ? 1 : 0);
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_vld && (i >= int'(sel_idx))) begin
            ent_d[i] = ent_up[i];
         end else begin
            ent_d[i] = ent_wk[i];
         end
         if (disp_fire && (i == tail)) begin
            ent_d[i] = disp_ent;
         end
      end
      count_d = count_q - CNT_W'(sel_vld) + CNT_W'(disp_fire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q  <= '0;
         exe_en_q <= 1'b0;
         rs2exe_q <= '0;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q  <= '0;
         exe_en_q <= 1'b0;
      end else begin
         ent_q    <= ent_d;
         count_q  <= count_d;
         exe_en_q <= sel_vld;
         if (sel_vld) begin
            rs2exe_q <= sel_bundle;
         end
      end
   end

   assign bus.exe_en = exe_en_q;
   assign bus.rs2exe = rs2exe_q;
   assign bus.count  = count_q;

endmodule

// File: tb/tb_rs_integer.sv
// Directed bench for rs_integer: vector table plus hand sequences for ordering, dual wakeup and async reset.
module tb_rs_integer;
   import core_pkg::*;

   localparam logic [9:0] ADD = 10'h000;
   localparam logic [9:0] SUB = 10'h100;
   localparam int NV = 28;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   rs_integer_if #(.DEPTH(4)) bus ();

   rs_integer #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [9:0]  inst;
      logic [5:0]  dest;
      logic        r1;
      logic [31:0] o1;
      logic        r2;
      logic [31:0] o2;
      logic [5:0]  ctag;
      logic [31:0] cval;
      logic        fl;
      logic        en;
      logic [79:0] bn;
      logic [2:0]  cnt;
      logic        rdy;
   } vec_t;

   vec_t vt [NV];

   function automatic vec_t mk(input logic dv, input logic [9:0] inst, input logic [5:0] dest,
                               input logic r1, input logic [31:0] o1,
                               input logic r2, input logic [31:0] o2,
                               input logic [5:0] ct, input logic [31:0] cv, input logic fl,
                               input logic en, input logic [79:0] bn,
                               input logic [2:0] cnt, input logic rdy);
      vec_t v;
      v.dv = dv; v.inst = inst; v.dest = dest; v.r1 = r1; v.o1 = o1; v.r2 = r2; v.o2 = o2;
      v.ctag = ct; v.cval = cv; v.fl = fl; v.en = en; v.bn = bn; v.cnt = cnt; v.rdy = rdy;
      return v;
   endfunction

   function automatic logic [79:0] bun(input logic [9:0] i, input logic [5:0] d,
                                       input logic [31:0] a, input logic [31:0] b);
      return {i, d, a, b};
   endfunction

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic [9:0] inst, input logic [5:0] dest,
                        input logic r1, input logic [31:0] o1, input logic r2, input logic [31:0] o2,
                        input logic [5:0] ct, input logic [31:0] cv, input logic fl);
      bus.disp_valid    = dv;
      bus.disp_inst     = inst;
      bus.disp_dest     = dest;
      bus.disp_opr1_rdy = r1;
      bus.disp_opr1     = o1;
      bus.disp_opr2_rdy = r2;
      bus.disp_opr2     = o2;
      bus.cdb           = {ct, cv};
      bus.flush         = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //       dv inst dest r1 o1  r2 o2    ctag cval  fl   en bundle                  cnt rdy
      vt[0]  = mk(1, ADD, 5,  1, 7,  1, 3,   0, 0,    0,   0, 80'h0,                   1, 1);
      vt[1]  = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(ADD, 5, 7, 3),       0, 1);
      vt[2]  = mk(1, SUB, 9,  0, 12, 1, 1,   0, 0,    0,   0, 80'h0,                   1, 1);
      vt[3]  = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   0, 80'h0,                   1, 1);
      vt[4]  = mk(0, ADD, 0,  0, 0,  0, 0,   12, 100, 0,   0, 80'h0,                   1, 1);
      vt[5]  = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(SUB, 9, 100, 1),     0, 1);
      vt[6]  = mk(1, ADD, 3,  0, 4,  1, 2,   4, 55,   0,   0, 80'h0,                   1, 1);
      vt[7]  = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(ADD, 3, 55, 2),      0, 1);
      vt[8]  = mk(1, ADD, 10, 0, 8,  1, 20,  0, 0,    0,   0, 80'h0,                   1, 1);
      vt[9]  = mk(1, ADD, 11, 0, 8,  1, 21,  0, 0,    0,   0, 80'h0,                   2, 1);
      vt[10] = mk(1, ADD, 12, 0, 8,  1, 22,  0, 0,    0,   0, 80'h0,                   3, 1);
      vt[11] = mk(1, ADD, 13, 0, 8,  1, 23,  0, 0,    0,   0, 80'h0,                   4, 0);
      vt[12] = mk(1, ADD, 30, 1, 1,  1, 1,   0, 0,    0,   0, 80'h0,                   4, 0);
      vt[13] = mk(0, ADD, 0,  0, 0,  0, 0,   8, 1,    0,   0, 80'h0,                   4, 0);
      vt[14] = mk(1, ADD, 30, 1, 1,  1, 1,   0, 0,    0,   1, bun(ADD, 10, 1, 20),     3, 1);
      vt[15] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(ADD, 11, 1, 21),     2, 1);
      vt[16] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(ADD, 12, 1, 22),     1, 1);
      vt[17] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   1, bun(ADD, 13, 1, 23),     0, 1);
      vt[18] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   0, 80'h0,                   0, 1);
      vt[19] = mk(1, ADD, 14, 0, 0,  1, 5,   0, 32'hDEAD, 0, 0, 80'h0,                 1, 1);
      vt[20] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 32'hDEAD, 0, 0, 80'h0,                 1, 1);
      vt[21] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   0, 80'h0,                   1, 1);
      vt[22] = mk(1, ADD, 15, 0, 9,  1, 0,   0, 0,    0,   0, 80'h0,                   2, 1);
      vt[23] = mk(1, ADD, 16, 0, 9,  1, 0,   0, 0,    0,   0, 80'h0,                   3, 1);
      vt[24] = mk(1, ADD, 17, 1, 1,  1, 1,   0, 0,    1,   0, 80'h0,                   0, 1);
      vt[25] = mk(1, ADD, 18, 1, 1,  1, 2,   0, 0,    0,   0, 80'h0,                   1, 1);
      vt[26] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    1,   0, 80'h0,                   0, 1);
      vt[27] = mk(0, ADD, 0,  0, 0,  0, 0,   0, 0,    0,   0, 80'h0,                   0, 1);

      rst_n = 1'b0;
      drive(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset.exe_en",     bus.exe_en,     1'b0);
      chk("reset.rs2exe",     bus.rs2exe,     80'h0);
      chk("reset.count",      bus.count,      3'd0);
      chk("reset.disp_ready", bus.disp_ready, 1'b1);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].dv, vt[i].inst, vt[i].dest, vt[i].r1, vt[i].o1, vt[i].r2, vt[i].o2,
               vt[i].ctag, vt[i].cval, vt[i].fl);
         tick();
         chk($sformatf("row%0d.exe_en", i),     bus.exe_en,     vt[i].en);
         chk($sformatf("row%0d.count", i),      bus.count,      vt[i].cnt);
         chk($sformatf("row%0d.disp_ready", i), bus.disp_ready, vt[i].rdy);
         if (vt[i].en) begin
            chk($sformatf("row%0d.rs2exe", i), bus.rs2exe, vt[i].bn);
         end
      end

      // Younger ready entry overtakes an older one still waiting on its operand.
      drive(1, ADD, 23, 0, 2, 1, 4, 0, 0, 0);
      tick();
      drive(1, ADD, 24, 1, 6, 1, 7, 0, 0, 0);
      tick();
      chk("bypass.count_pre", bus.count, 3'd2);
      drive(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("bypass.young_en",  bus.exe_en, 1'b1);
      chk("bypass.young_bun", bus.rs2exe, bun(ADD, 24, 6, 7));
      chk("bypass.count_mid", bus.count,  3'd1);
      drive(0, ADD, 0, 0, 0, 0, 0, 2, 11, 0);
      tick();
      chk("bypass.wake_en",   bus.exe_en, 1'b0);
      drive(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("bypass.old_en",    bus.exe_en, 1'b1);
      chk("bypass.old_bun",   bus.rs2exe, bun(ADD, 23, 11, 4));
      chk("bypass.count_end", bus.count,  3'd0);

      // Both operands wait on the same tag and wake from one broadcast.
      drive(1, SUB, 22, 0, 7, 0, 7, 0, 0, 0);
      tick();
      drive(0, ADD, 0, 0, 0, 0, 0, 7, 9, 0);
      tick();
      chk("dual.wake_en", bus.exe_en, 1'b0);
      drive(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("dual.en",    bus.exe_en, 1'b1);
      chk("dual.bun",   bus.rs2exe, bun(SUB, 22, 9, 9));
      chk("dual.count", bus.count,  3'd0);

      // Asynchronous reset mid-stream with one entry queued and one issuing.
      drive(1, ADD, 20, 1, 1, 1, 2, 0, 0, 0);
      tick();
      drive(1, ADD, 21, 1, 3, 1, 4, 0, 0, 0);
      tick();
      chk("arst.pre_en",  bus.exe_en, 1'b1);
      chk("arst.pre_bun", bus.rs2exe, bun(ADD, 20, 1, 2));
      drive(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.exe_en",     bus.exe_en,     1'b0);
      chk("arst.rs2exe",     bus.rs2exe,     80'h0);
      chk("arst.count",      bus.count,      3'd0);
      chk("arst.disp_ready", bus.disp_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst.post_en",    bus.exe_en, 1'b0);
      chk("arst.post_count", bus.count,  3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
